vga_scanout: RTL and testbench

Display-side endpoint of the game's pixel-plot interface. Accepts single-pixel writes (x, y, colour, plot) from the game FSM into a 160x120, 3-bit-per-pixel framebuffer, and continuously scans that framebuffer out as 640x480 at 60 Hz VGA, replicating each stored pixel 4x4. Also emits a once-per-frame tick so the game FSM can pace its updates without a separate frame divider.

---
 rtl/vga_scanout_if.sv | 19 +
 rtl/vga_scanout.sv | 208 ++++++++++++++++++++
 tb/tb_vga_scanout.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// vga_scanout_if
//   Pixel-plot bus between the game FSM (master) and the display endpoint
//   (slave).
//   plot       : write strobe, one pixel per clk while high
//   x, y       : write column 0..159 / row 0..119
//   colour     : {R,G,B}, one bit per channel
//   busy       : framebuffer clear in progress, plots are dropped
//   frame_tick : one-clk pulse at the start of each vertical blank
interface vga_scanout_if;
   logic       plot;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       busy;
   logic       frame_tick;

   modport master (output plot, x, y, colour, input busy, frame_tick);
   modport slave  (input plot, x, y, colour, output busy, frame_tick);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout
//   160x120x3 framebuffer written one pixel per clk over the plot bus and
//   scanned out as 640x480@60 VGA (each stored pixel shown 4x4) from a 50 MHz
//   clock with a clk/2 pixel enable.
//   Optional feature macro VGA_SCANOUT_CLEAR_EN: after every reset a clear
//   engine writes colour 0 to all 19200 entries, one per clk, holding busy
//   high and ignoring plots meanwhile. Without it busy is tied low and the
//   framebuffer power-up contents are undefined.
// Ports
//   clk                 : 50 MHz system clock
//   rst                 : synchronous reset, active-low
//   pix                 : plot bus (slave side), see vga_scanout_if
//   vga_clk             : 25 MHz pixel clock (registered pixel enable)
//   vga_hs, vga_vs      : active-low syncs
//   vga_blank_n         : high in the visible region
//   vga_sync_n          : constant 0
//   vga_r, vga_g, vga_b : colour bit replicated over 10 bits
module vga_scanout #(
   parameter int FB_W = 160,
   parameter int FB_H = 120
) (
   input  logic           clk,
   input  logic           rst,
   vga_scanout_if.slave   pix,
   output logic           vga_clk,
   output logic           vga_hs,
   output logic           vga_vs,
   output logic           vga_blank_n,
   output logic           vga_sync_n,
   output logic [9:0]     vga_r,
   output logic [9:0]     vga_g,
   output logic [9:0]     vga_b
);

   localparam int             FB_DEPTH = FB_W * FB_H;
   localparam logic [7:0]     FB_W8    = 8'(FB_W);
   localparam logic [7:0]     FB_H8    = 8'(FB_H);
   localparam logic [9:0]     H_LAST   = 10'd799;
   localparam logic [9:0]     V_LAST   = 10'd524;
   localparam logic [9:0]     H_VIS    = 10'd640;
   localparam logic [9:0]     V_VIS    = 10'd480;

   // row*160 + col as two shifts; 15 bits covers all 19200 entries
   function automatic logic [14:0] fb_addr(input logic [7:0] row, input logic [7:0] col);
      return ({7'd0, row} << 7) + ({7'd0, row} << 5) + {7'd0, col};
   endfunction

   logic [2:0]  fb_mem [FB_DEPTH];

   logic        pe_q, pe_d;
   logic        vga_clk_q, vga_clk_d;
   logic [9:0]  hc_q, hc_d;
   logic [9:0]  vc_q, vc_d;
   logic        tick_q, tick_d;

   logic        vis_p0, hs_p0, vs_p0;
   logic [14:0] rd_addr_p0;

   logic        vis_p1_q, vis_p1_d;
   logic        hs_p1_q, hs_p1_d;
   logic        vs_p1_q, vs_p1_d;
   logic [2:0]  rd_p1_q;

   logic        blank_p2_q, blank_p2_d;
   logic        hs_p2_q, hs_p2_d;
   logic        vs_p2_q, vs_p2_d;
   logic [2:0]  rgb_p2_q, rgb_p2_d;

   logic        plot_ok;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [2:0]  wr_data;

   // Stage p0: pixel enable and raster counters
   always_comb begin
      pe_d      = ~pe_q;
      vga_clk_d = pe_q;
      hc_d      = hc_q;
      vc_d      = vc_q;
      if (pe_q) begin
         if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
      // Fires on the edge that moves the raster from (799,479) to (0,480)
      tick_d = pe_q && (hc_q == H_LAST) && (vc_q == V_VIS - 10'd1);
   end

   always_comb begin
      vis_p0     = (hc_q < H_VIS) && (vc_q < V_VIS);
      hs_p0      = !((hc_q >= 10'd656) && (hc_q <= 10'd751));
      vs_p0      = !((vc_q == 10'd490) || (vc_q == 10'd491));
      // Blanked positions would index past the array; they are masked later
      rd_addr_p0 = vis_p0 ? fb_addr(vc_q[9:2], hc_q[9:2]) : 15'd0;
   end

   // Stage p1: registered memory read, syncs travel alongside
   always_comb begin
      vis_p1_d = vis_p0;
      hs_p1_d  = hs_p0;
      vs_p1_d  = vs_p0;
   end

   // Stage p2: output register
   always_comb begin
      blank_p2_d = vis_p1_q;
      hs_p2_d    = hs_p1_q;
      vs_p2_d    = vs_p1_q;
      rgb_p2_d   = vis_p1_q ? rd_p1_q : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pe_q       <= 1'b0;
         vga_clk_q  <= 1'b0;
         hc_q       <= 10'd0;
         vc_q       <= 10'd0;
         tick_q     <= 1'b0;
         vis_p1_q   <= 1'b0;
         hs_p1_q    <= 1'b1;
         vs_p1_q    <= 1'b1;
         blank_p2_q <= 1'b0;
         hs_p2_q    <= 1'b1;
         vs_p2_q    <= 1'b1;
         rgb_p2_q   <= 3'b000;
      end else begin
         pe_q       <= pe_d;
         vga_clk_q  <= vga_clk_d;
         hc_q       <= hc_d;
         vc_q       <= vc_d;
         tick_q     <= tick_d;
         vis_p1_q   <= vis_p1_d;
         hs_p1_q    <= hs_p1_d;
         vs_p1_q    <= vs_p1_d;
         blank_p2_q <= blank_p2_d;
         hs_p2_q    <= hs_p2_d;
         vs_p2_q    <= vs_p2_d;
         rgb_p2_q   <= rgb_p2_d;
      end
   end

   // Out-of-range coordinates are rejected before forming the address so
   // they cannot wrap onto another row.
   assign plot_ok = pix.plot && (pix.x < FB_W8) && (pix.y < FB_H8);

`ifdef VGA_SCANOUT_CLEAR_EN
   localparam logic [14:0] FB_LAST = 15'(FB_DEPTH - 1);

   logic        busy_q, busy_d;
   logic [14:0] clr_addr_q, clr_addr_d;

   always_comb begin
      busy_d     = busy_q;
      clr_addr_d = clr_addr_q;
      if (busy_q) begin
         if (clr_addr_q == FB_LAST) busy_d = 1'b0;
         else                       clr_addr_d = clr_addr_q + 15'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q     <= 1'b1;
         clr_addr_q <= 15'd0;
      end else begin
         busy_q     <= busy_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // The clear owns the single write port; no clear writes while held in reset
   always_comb begin
      wr_en   = busy_q ? rst : plot_ok;
      wr_addr = busy_q ? clr_addr_q : fb_addr(pix.y, pix.x);
      wr_data = busy_q ? 3'b000 : pix.colour;
   end

   assign pix.busy = busy_q;
`else
   always_comb begin
      wr_en   = plot_ok;
      wr_addr = fb_addr(pix.y, pix.x);
      wr_data = pix.colour;
   end

   assign pix.busy = 1'b0;
`endif

   // Read-before-write: a same-address read on the write edge sees old data
   always_ff @(posedge clk) begin
      if (wr_en) fb_mem[wr_addr] <= wr_data;
      rd_p1_q <= fb_mem[rd_addr_p0];
   end

   assign pix.frame_tick = tick_q;
   assign vga_clk        = vga_clk_q;
   assign vga_hs         = hs_p2_q;
   assign vga_vs         = vs_p2_q;
   assign vga_blank_n    = blank_p2_q;
   assign vga_sync_n     = 1'b0;
   assign vga_r          = {10{rgb_p2_q[2]}};
   assign vga_g          = {10{rgb_p2_q[1]}};
   assign vga_b          = {10{rgb_p2_q[0]}};

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Randomised plot traffic against a behavioural model of the display.
//   A predictor derives every pin value from the elapsed clk count and a
//   model framebuffer and queues it; a monitor pops and compares each cycle.
module tb_vga_scanout;
   localparam int FB_N = 19200;
`ifdef VGA_SCANOUT_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
   logic [9:0] vga_r, vga_g, vga_b;

   vga_scanout_if pif();

   vga_scanout #(.FB_W(160), .FB_H(120)) dut (
      .clk(clk), .rst(rst), .pix(pif),
      .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #10 clk = ~clk;

   typedef struct { int w; int addr; logic [2:0] c; } wr_t;
   typedef struct { int j; logic [5:0] ctl; logic [2:0] rgb; bit rk; } exp_t;

   // j = clk intervals since reset release (interval 0 follows the first
   // edge with rst high); -1 while in reset.
   int         j = -1;
   wr_t        pend[$];
   exp_t       expq[$];
   logic [2:0] fb [FB_N];
   bit         known [FB_N];
   logic [2:0] cur [FB_N];
   int         checks = 0;
   int         passes = 0;
   bit         bmeas = 1'b0;
   int         bcount = 0;

   function automatic bit busy_model(input int jj);
      return CLR && (jj < FB_N - 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   // A write driven in interval w lands on the edge ending it; only reads
   // issued on later edges (outputs at interval >= w+3) can see it.
   task automatic apply_pending(input int upto);
      wr_t p;
      while (pend.size() > 0 && pend[0].w <= upto) begin
         p = pend.pop_front();
         fb[p.addr]    = p.c;
         known[p.addr] = 1'b1;
      end
   endtask

   task automatic drive(input bit p, input int xi, input int yi, input logic [2:0] c);
      int a;
      pif.plot   = p;
      pif.x      = 8'(xi);
      pif.y      = 8'(yi);
      pif.colour = c;
      if (p && xi < 160 && yi < 120 && !busy_model(j)) begin
         a = yi * 160 + xi;
         pend.push_back('{w: j, addr: a, c: c});
         cur[a] = c;
      end
   endtask

   task automatic drive_random();
      int r, xi, yi;
      r = $urandom_range(0, 15);
      if (r < 4) begin
         xi = $urandom_range(0, 159);
         yi = $urandom_range(0, 7);
         if (yi * 160 + xi == 5 * 160 + 10) drive(1'b0, 0, 0, 3'b000);
         else drive(1'b1, xi, yi, 3'($urandom_range(0, 7)));
      end else if (r == 4) begin
         if ($urandom_range(0, 1) == 1) begin
            xi = $urandom_range(160, 255);
            yi = $urandom_range(0, 7);
         end else begin
            xi = $urandom_range(0, 159);
            yi = $urandom_range(120, 255);
         end
         drive(1'b1, xi, yi, 3'b111);
      end else begin
         drive(1'b0, 0, 0, 3'b000);
      end
   endtask

   task automatic measure_busy();
      if (bmeas) begin
         if (pif.busy === 1'b1) bcount++;
         else bmeas = 1'b0;
      end
   endtask

   task automatic check_reset();
      chk("rst_vga_clk", int'(vga_clk), 0);
      chk("rst_hs", int'(vga_hs), 1);
      chk("rst_vs", int'(vga_vs), 1);
      chk("rst_blank_n", int'(vga_blank_n), 0);
      chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
      chk("rst_frame_tick", int'(pif.frame_tick), 0);
      chk("rst_sync_n", int'(vga_sync_n), 0);
      chk("rst_busy", int'(pif.busy), int'(CLR));
   endtask

   task automatic reset_pulse(input int n);
      @(negedge clk);
      pif.plot = 1'b0;
      rst = 1'b0;
      apply_pending(32'h7fffffff);
      repeat (n) @(negedge clk);
      check_reset();
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
      pif.plot = 1'b0;
      if (CLR) begin
         for (int a = 0; a < FB_N; a++) begin
            pend.push_back('{w: a - 1, addr: a, c: 3'b000});
            cur[a] = 3'b000;
         end
         bmeas  = 1'b1;
         bcount = 0;
         measure_busy();
      end
   endtask

   // Predictor: expected pins for the interval that this edge starts
   initial begin : predictor
      exp_t e;
      int   p, hc, vc, a;
      forever begin
         @(posedge clk);
         e.rgb = 3'b000;
         e.rk  = 1'b1;
         if (!rst) begin
            j = -1;
            e.ctl = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CLR};
         end else begin
            j = j + 1;
            apply_pending(j - 3);
            e.ctl = {(j % 2 == 1), 1'b1, 1'b1, 1'b0,
                     (j % 2 == 1) && (((j + 1) / 2) % 420000 == 384000),
                     busy_model(j)};
            if (j > 0) begin
               p  = ((j - 1) / 2) % 420000;
               hc = p % 800;
               vc = p / 800;
               e.ctl[4] = !(hc >= 656 && hc < 752);
               e.ctl[3] = !(vc == 490 || vc == 491);
               e.ctl[2] = (hc < 640) && (vc < 480);
               if (e.ctl[2]) begin
                  a     = (vc / 4) * 160 + hc / 4;
                  e.rgb = fb[a];
                  e.rk  = known[a];
               end
            end
         end
         e.j = j;
         expq.push_back(e);
      end
   end

   // Monitor: compare every cycle's pins against the queued expectation
   initial begin : monitor
      exp_t       e;
      logic [5:0] act;
      logic [29:0] rgb_act, rgb_exp;
      bit         ok;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e       = expq.pop_front();
            act     = {vga_clk, vga_hs, vga_vs, vga_blank_n, pif.frame_tick, pif.busy};
            rgb_act = {vga_r, vga_g, vga_b};
            rgb_exp = {{10{e.rgb[2]}}, {10{e.rgb[1]}}, {10{e.rgb[0]}}};
            ok = (act === e.ctl) && (vga_sync_n === 1'b0) &&
                 (!e.rk || rgb_act === rgb_exp);
            checks++;
            if (ok) passes++;
            else $display("FAIL scan j=%0d: clk/hs/vs/blank/tick/busy=%b rgb=%h sync_n=%b, want %b rgb=%h (known=%0d)",
                          e.j, act, rgb_act, vga_sync_n, e.ctl, rgb_exp, e.rk);
         end
      end
   end

   initial begin : stimulus
      int fill, dir;
      pif.plot = 1'b0; pif.x = 8'd0; pif.y = 8'd0; pif.colour = 3'b000;
      repeat (4) @(negedge clk);
      check_reset();
      release_rst();

      // Phase A: fill rows 0..7, directed writes, then random traffic
      fill = 0;
      dir  = 0;
      while (j < 39000) begin
         @(negedge clk);
         measure_busy();
         if (busy_model(j)) drive(1'b0, 0, 0, 3'b000);
         else if (fill < 1280) begin
            drive(1'b1, fill % 160, fill / 160, 3'($urandom_range(0, 7)));
            fill++;
         end else if (dir < 4) begin
            case (dir)
               0:       drive(1'b1, 10, 5, 3'b101);
               1:       drive(1'b1, 160, 0, 3'b111);
               2:       drive(1'b1, 200, 0, 3'b111);
               default: drive(1'b1, 0, 205, 3'b111);
            endcase
            dir++;
         end else if (j == 28999) begin
            // lands on the edge that reads raster (100,18) = pixel (25,4)
            drive(1'b1, 25, 4, cur[4 * 160 + 25] ^ 3'b111);
         end else begin
            drive_random();
         end
      end
`ifdef VGA_SCANOUT_CLEAR_EN
      chk("busy_len_a", bcount, FB_N);
`endif

      // Phase B: mid-frame reset, then a plot issued at j=5000
      reset_pulse(3);
      release_rst();
      while (j < 30000) begin
         @(negedge clk);
         measure_busy();
         if (j == 5000) drive(1'b1, 11, 2, 3'b111);
         else if (busy_model(j)) drive(1'b0, 0, 0, 3'b000);
         else drive_random();
      end
`ifdef VGA_SCANOUT_CLEAR_EN
      chk("busy_len_b", bcount, FB_N);
`endif
      @(negedge clk);
      pif.plot = 1'b0;
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
